// File: rtl/seq_pkg.sv
// Shared types and encodings for the ALU op sequencer: FSM states, RV32I
// opcode/funct fields, ALU control codes and the decoded-instruction bundle.
package seq_pkg;

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [2:0] F3_ADD    = 3'b000;
   localparam logic [2:0] F3_BNE    = 3'b001;
   localparam logic [6:0] F7_ADD    = 7'b0000000;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;

   typedef struct packed {
      logic        legal;
      logic        is_branch;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        alu_src;
      logic [2:0]  alu_ctrl;
      logic [31:0] imm;
   } decoded_t;

   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

   function automatic logic [31:0] sext13(input logic [12:0] v);
      return {{19{v[12]}}, v};
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder for the addi/add/bne subset; everything else
// is flagged as not legal.
module instr_decoder
   import seq_pkg::*;
(
   input  logic [31:0] instr,
   output decoded_t    dec
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   always_comb begin
      // NOTE: every field gets a default first so no path can infer a latch.
      dec          = '0;
      dec.rs1      = instr[19:15];
      dec.rs2      = instr[24:20];
      dec.rd       = instr[11:7];
      dec.alu_ctrl = ALU_ADD;

      case (opcode)
         OP_IMM: begin
            if (funct3 == F3_ADD) begin
               dec.legal   = 1'b1;
               dec.alu_src = 1'b1;
               dec.imm     = sext12(instr[31:20]);
            end
         end
         OP_REG: begin
            if (funct3 == F3_ADD && funct7 == F7_ADD) begin
               dec.legal = 1'b1;
            end
         end
         OP_BRANCH: begin
            if (funct3 == F3_BNE) begin
               dec.legal     = 1'b1;
               dec.is_branch = 1'b1;
               dec.alu_ctrl  = ALU_SUB;
               dec.rd        = '0;
               dec.imm       = sext13({instr[31], instr[7], instr[30:25],
                                       instr[11:8], 1'b0});
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller: accepts one instruction, walks DECODE -> EXEC -> WB,
// drives the datapath controls and counts retired instructions.
module alu_op_sequencer
   import seq_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      instr_valid,
   output logic                      instr_ready,
   input  logic [31:0]               instr,
   input  logic                      eq,
   output logic [REG_ADDR_WIDTH-1:0] rs1,
   output logic [REG_ADDR_WIDTH-1:0] rs2,
   output logic [REG_ADDR_WIDTH-1:0] rd,
   output logic                      reg_write,
   output logic                      alu_src,
   output logic [2:0]                alu_ctrl,
   output logic [ADDRESS_WIDTH-1:0]  imm_op,
   output logic                      branch_taken,
   output logic                      done,
   output logic                      illegal,
   output logic [ADDRESS_WIDTH-1:0]  instret
);

   state_t      state;
   state_t      next_state;
   logic [31:0] instr_q;
   decoded_t    dec;
   logic        accept;
   logic        write_en_q;
   logic        is_branch_q;

   assign accept = instr_valid && instr_ready;

   instr_decoder u_decoder (
      .instr (instr_q),
      .dec   (dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = DECODE;
         DECODE:  next_state = dec.legal ? EXEC : IDLE;
         EXEC:    next_state = WB;
         WB:      next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Illegal is reported while the bad word sits in DECODE.
   assign illegal = (state == DECODE) && !dec.legal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q     <= '0;
         instr_ready <= 1'b0;
      end else begin
         if (accept) instr_q <= instr;
         instr_ready <= (next_state == IDLE);
      end
   end

   // Datapath controls are loaded only by a legal DECODE and held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1         <= '0;
         rs2         <= '0;
         rd          <= '0;
         alu_src     <= 1'b0;
         alu_ctrl    <= ALU_ADD;
         imm_op      <= '0;
         write_en_q  <= 1'b0;
         is_branch_q <= 1'b0;
      end else if (state == DECODE && dec.legal) begin
         rs1         <= REG_ADDR_WIDTH'(dec.rs1);
         rs2         <= REG_ADDR_WIDTH'(dec.rs2);
         rd          <= REG_ADDR_WIDTH'(dec.rd);
         alu_src     <= dec.alu_src;
         alu_ctrl    <= dec.alu_ctrl;
         imm_op      <= ADDRESS_WIDTH'($signed(dec.imm));
         write_en_q  <= !dec.is_branch && (dec.rd != 5'd0);
         is_branch_q <= dec.is_branch;
      end
   end

   // WB pulses are registered on the EXEC->WB edge, which is also where eq is sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write    <= 1'b0;
         branch_taken <= 1'b0;
         done         <= 1'b0;
         instret      <= '0;
      end else begin
         reg_write    <= (state == EXEC) && write_en_q;
         branch_taken <= (state == EXEC) && is_branch_q && !eq;
         done         <= (state == EXEC);
         if (state == EXEC) instret <= instret + ADDRESS_WIDTH'(1);
      end
   end

endmodule
